map_port_arbiter: RTL and testbench

MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

---
 rtl/map_port_arbiter_pkg.sv | 25 ++
 rtl/map_port_arbiter_rr_pick.sv | 26 ++
 rtl/map_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_map_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/map_port_arbiter_pkg.sv
// Shared map definitions: playfield geometry, tile codes and arbiter state encoding.
package map_port_arbiter_pkg;

    localparam int NUM_ROW    = 11;
    localparam int NUM_COL    = 19;
    localparam int DEPTH      = NUM_ROW * NUM_COL;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int DATA_WIDTH = 3;

    localparam logic [DATA_WIDTH-1:0] EMPTY = 3'd0;
    localparam logic [DATA_WIDTH-1:0] WALL  = 3'd1;
    localparam logic [DATA_WIDTH-1:0] BRICK = 3'd2;
    localparam logic [DATA_WIDTH-1:0] BOMB  = 3'd3;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/map_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!o_any && i_req[(int'(i_ptr) + off) % NUM_REQ]) begin
                o_any = 1'b1;
                o_gnt[(int'(i_ptr) + off) % NUM_REQ] = 1'b1;
                o_idx = IDX_W'((int'(i_ptr) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/map_port_arbiter.sv
// Single-port map BRAM arbiter: write priority, round-robin reads, bounded read lock.
module map_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = map_port_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = map_port_arbiter_pkg::DATA_WIDTH,
    parameter int LOCK_MAX   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 rd_req,
    input  logic [NUM_REQ-1:0]                 rd_lock,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]                 rd_gnt,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    input  logic                               wr_req,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               wr_gnt,
    output logic [ADDR_WIDTH-1:0]              map_addr,
    output logic                               map_we,
    output logic [DATA_WIDTH-1:0]              map_wdata,
    input  logic [DATA_WIDTH-1:0]              map_rdata
);

    import map_port_arbiter_pkg::*;

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    arb_state_t         r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_owner;
    logic [CW-1:0]      r_lock_cnt;
    logic [NUM_REQ-1:0] r_rsp_valid;

    arb_state_t         w_state_nxt;
    logic [IW-1:0]      w_ptr_nxt;
    logic [IW-1:0]      w_owner_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [CW-1:0]      w_cnt_inc;
    logic [NUM_REQ-1:0] w_rd_gnt;
    logic               w_wr_gnt;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr_pick (
        .i_req (rd_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_cnt_inc = r_lock_cnt + CW'(1);

    // A lock always ends on its own after LOCK_MAX grants, so writes never starve.
    always_comb begin
        w_rd_gnt    = '0;
        w_wr_gnt    = 1'b0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_lock_cnt;
        if (!rst) begin
            case (r_state)
                ST_ARB: begin
                    if (wr_req) begin
                        w_wr_gnt = 1'b1;
                    end else if (w_pick_any) begin
                        w_rd_gnt  = w_pick_gnt;
                        w_ptr_nxt = (w_pick_idx == IW'(NUM_REQ - 1)) ? '0 : w_pick_idx + IW'(1);
                        if (rd_lock[w_pick_idx] && (LOCK_MAX > 1)) begin
                            w_state_nxt = ST_LOCK;
                            w_owner_nxt = w_pick_idx;
                            w_cnt_nxt   = CW'(1);
                        end
                    end
                end
                ST_LOCK: begin
                    if (rd_req[r_owner]) begin
                        w_rd_gnt[r_owner] = 1'b1;
                        if (!rd_lock[r_owner] || (w_cnt_inc == CNT_MAX)) begin
                            w_state_nxt = ST_ARB;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = ST_ARB;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_ARB;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ARB;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_lock_cnt  <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_lock_cnt  <= w_cnt_nxt;
            r_rsp_valid <= w_rd_gnt;
        end
    end

    always_comb begin
        map_addr  = '0;
        map_wdata = '0;
        if (w_wr_gnt) begin
            map_addr  = wr_addr;
            map_wdata = wr_data;
        end else if (|w_rd_gnt) begin
            map_wdata = wr_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_rd_gnt[i]) begin
                    map_addr = rd_addr[i];
                end
            end
        end
    end

    assign rd_gnt = w_rd_gnt;
    assign wr_gnt = w_wr_gnt;
    assign map_we = w_wr_gnt;

    // Masking with rst drops a response that would otherwise surface during reset.
    assign rsp_valid = rst ? '0 : r_rsp_valid;
    assign rsp_data  = (|rsp_valid) ? map_rdata : EMPTY;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter with a read-first BRAM model on the map port.
module tb_map_port_arbiter;

    import map_port_arbiter_pkg::*;

    localparam int NR = 3;
    localparam int AW = 8;
    localparam int DW = 3;
    localparam int LM = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        rd_req;
    logic [NR-1:0]        rd_lock;
    logic [NR-1:0][AW-1:0] rd_addr;
    logic [NR-1:0]        rd_gnt;
    logic [NR-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 wr_req;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 wr_gnt;
    logic [AW-1:0]        map_addr;
    logic                 map_we;
    logic [DW-1:0]        map_wdata;
    logic [DW-1:0]        map_rdata = '0;

    logic [DW-1:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    int g_seq [6] = '{1, 2, 4, 1, 2, 4};
    int a_seq [6] = '{5, 10, 20, 5, 10, 20};
    int d_seq [6] = '{5, 2, 4, 5, 2, 4};

    always #5 clk = ~clk;

    map_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOCK_MAX   (LM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_lock   (rd_lock),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .map_addr  (map_addr),
        .map_we    (map_we),
        .map_wdata (map_wdata),
        .map_rdata (map_rdata)
    );

    // Read-first BRAM; contents preset to the low address bits during reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
        end else if (map_we) begin
            mem[map_addr] <= map_wdata;
        end
        map_rdata <= mem[map_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        rd_req     = 3'b111;
        rd_lock    = 3'b000;
        rd_addr[0] = 8'd5;
        rd_addr[1] = 8'd10;
        rd_addr[2] = 8'd20;
        wr_req     = 1'b1;
        wr_addr    = 8'd3;
        wr_data    = 3'd1;
        tick();
        tick();
        #1;
        chk("rst_rd_gnt", 32'(rd_gnt), 0);
        chk("rst_wr_gnt", 32'(wr_gnt), 0);
        chk("rst_map_we", 32'(map_we), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_ARB));

        // Round robin over three steady requesters.
        rst    = 1'b0;
        wr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_gnt", 32'(rd_gnt), 32'(g_seq[i]));
            chk("rr_addr", 32'(map_addr), 32'(a_seq[i]));
            if (i == 0) begin
                chk("rr_rsp_valid0", 32'(rsp_valid), 0);
                chk("rr_rsp_data0", 32'(rsp_data), 0);
            end else begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(g_seq[i-1]));
                chk("rr_rsp_data", 32'(rsp_data), 32'(d_seq[i-1]));
            end
            tick();
        end

        // Write beats reads in ARB.
        rd_req  = 3'b011;
        wr_req  = 1'b1;
        wr_addr = 8'd7;
        wr_data = 3'd6;
        #1;
        chk("wr_gnt", 32'(wr_gnt), 1);
        chk("wr_rd_gnt", 32'(rd_gnt), 0);
        chk("wr_map_we", 32'(map_we), 1);
        chk("wr_map_addr", 32'(map_addr), 7);
        chk("wr_map_wdata", 32'(map_wdata), 6);
        chk("wr_rsp_valid", 32'(rsp_valid), 4);
        chk("wr_rsp_data", 32'(rsp_data), 4);
        tick();
        wr_req = 1'b0;
        #1;
        chk("after_wr_gnt0", 32'(rd_gnt), 1);
        chk("after_wr_we", 32'(map_we), 0);
        chk("after_wr_rsp_valid", 32'(rsp_valid), 0);
        chk("after_wr_rsp_data", 32'(rsp_data), 0);
        tick();
        #1;
        chk("after_wr_gnt1", 32'(rd_gnt), 2);
        chk("after_wr_rsp1", 32'(rsp_valid), 1);
        chk("after_wr_data1", 32'(rsp_data), 5);
        tick();

        // Read back the written tile, then an idle cycle with stray locks.
        rd_req     = 3'b100;
        rd_addr[2] = 8'd7;
        #1;
        chk("rb_gnt", 32'(rd_gnt), 4);
        chk("rb_addr", 32'(map_addr), 7);
        tick();
        rd_req     = 3'b000;
        rd_lock    = 3'b111;
        rd_addr[2] = 8'd20;
        #1;
        chk("idle_gnt", 32'(rd_gnt), 0);
        chk("idle_addr", 32'(map_addr), 0);
        chk("idle_wdata", 32'(map_wdata), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 4);
        chk("idle_rsp_data", 32'(rsp_data), 6);
        tick();
        chk("idle_lock_ignored", 32'(dut.r_state), 32'(ST_ARB));

        // Requester 0 locks for LOCK_MAX grants while a write waits.
        rd_req  = 3'b011;
        rd_lock = 3'b001;
        #1;
        chk("lk_gnt1", 32'(rd_gnt), 1);
        tick();
        wr_req  = 1'b1;
        wr_addr = 8'd9;
        wr_data = 3'd3;
        #1;
        chk("lk_gnt2", 32'(rd_gnt), 1);
        chk("lk_wr_blk2", 32'(wr_gnt), 0);
        chk("lk_rsp2", 32'(rsp_valid), 1);
        chk("lk_data2", 32'(rsp_data), 5);
        tick();
        #1;
        chk("lk_gnt3", 32'(rd_gnt), 1);
        chk("lk_wr_blk3", 32'(wr_gnt), 0);
        tick();
        #1;
        chk("lk_gnt4", 32'(rd_gnt), 1);
        chk("lk_wr_blk4", 32'(wr_gnt), 0);
        tick();
        #1;
        chk("lk_wr5", 32'(wr_gnt), 1);
        chk("lk_rd5", 32'(rd_gnt), 0);
        chk("lk_addr5", 32'(map_addr), 9);
        tick();
        wr_req = 1'b0;
        #1;
        chk("lk_next_req1", 32'(rd_gnt), 2);
        chk("lk_next_rsp", 32'(rsp_valid), 0);
        tick();

        // Requester 1 locks then drops its request after two grants.
        rd_req  = 3'b010;
        rd_lock = 3'b010;
        #1;
        chk("dr_gnt1", 32'(rd_gnt), 2);
        chk("dr_rsp1", 32'(rsp_valid), 2);
        chk("dr_data1", 32'(rsp_data), 2);
        tick();
        #1;
        chk("dr_gnt2", 32'(rd_gnt), 2);
        chk("dr_state_lock", 32'(dut.r_state), 32'(ST_LOCK));
        tick();
        rd_req = 3'b100;
        #1;
        chk("dr_blocked", 32'(rd_gnt), 0);
        tick();
        rd_req  = 3'b101;
        rd_lock = 3'b000;
        #1;
        chk("dr_state_arb", 32'(dut.r_state), 32'(ST_ARB));
        chk("dr_cnt_clr", 32'(dut.r_lock_cnt), 0);
        chk("dr_ptr_gnt", 32'(rd_gnt), 4);
        tick();

        // Reset the cycle after a locking grant.
        rd_req  = 3'b010;
        rd_lock = 3'b010;
        #1;
        chk("rs_gnt", 32'(rd_gnt), 2);
        tick();
        rst = 1'b1;
        #1;
        chk("rs_gnt_held", 32'(rd_gnt), 0);
        chk("rs_we_held", 32'(map_we), 0);
        chk("rs_rsp_drop", 32'(rsp_valid), 0);
        chk("rs_data_drop", 32'(rsp_data), 0);
        tick();
        rst     = 1'b0;
        rd_req  = 3'b110;
        rd_lock = 3'b000;
        #1;
        chk("rs_state", 32'(dut.r_state), 32'(ST_ARB));
        chk("rs_rsp_after", 32'(rsp_valid), 0);
        chk("rs_first_gnt", 32'(rd_gnt), 2);
        tick();
        #1;
        chk("rs_second_gnt", 32'(rd_gnt), 4);
        chk("rs_rsp_second", 32'(rsp_valid), 2);
        chk("rs_data_second", 32'(rsp_data), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
